if_id_stage: RTL

- Fetch and F/D pipeline stage for the RV32I 5-stage core.
- Owns the PC, issues instruction-memory requests, and registers fetched instructions into D.
- Packs the decoded 24-bit control word D_out consumed by the pipeline controller, and generates the D-stage immediate.
- Honours load-use stall, E-stage redirects (jal, jalr, taken branch) and instruction-memory wait states.

---
 rtl/if_id_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// Fetch and F/D pipeline register for the RV32I 5-stage core.
// Owns the PC, drives instruction-memory requests, registers the fetched
// instruction into D, and decodes the packed control word and immediate.
// Optional build macro IF_ID_PERF_CNT_EN adds stall/flush performance counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        next_pc_sel,
  input  logic [31:0] jb_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_ready,
  output logic [23:0] D_out,
  output logic [31:0] D_inst,
  output logic [31:0] D_pc,
  output logic [31:0] D_imm,
  output logic        D_valid
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  // What the F/D registers do at the coming edge, in priority order.
  typedef enum logic [1:0] {
    ACT_REDIRECT,
    ACT_HOLD,
    ACT_FETCH,
    ACT_WAIT
  } act_e;

  logic [31:0] pc_q;
  logic [31:0] d_inst_q;
  logic [31:0] d_pc_q;
  logic        d_valid_q;
  logic [31:0] inst_eff;
  act_e        act;

  // Pick this cycle's action: a redirect beats a stall, a stall beats a wait state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    act = ACT_FETCH;
    if (!next_pc_sel)    act = ACT_REDIRECT;
    else if (stall)      act = ACT_HOLD;
    else if (!im_ready)  act = ACT_WAIT;
  end

  // PC and F/D register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      d_inst_q  <= NOP_INST;
      d_pc_q    <= 32'h0;
      d_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (act)
        ACT_REDIRECT: begin
          pc_q      <= jb_target & 32'hFFFF_FFFC;
          d_inst_q  <= NOP_INST;
          d_valid_q <= 1'b0;
        end
        ACT_FETCH: begin
          d_inst_q  <= im_rdata;
          d_pc_q    <= pc_q;
          d_valid_q <= 1'b1;
          pc_q      <= pc_q + 32'd4;  // wraps naturally modulo 2^32
        end
        ACT_WAIT: begin
          d_inst_q  <= NOP_INST;
          d_valid_q <= 1'b0;
        end
        default: ;  // ACT_HOLD: everything keeps its value
      endcase
    end
  end

  // While E redirects, the wrong-path instruction in D is presented as a bubble.
  always_comb begin
    inst_eff = next_pc_sel ? d_inst_q : NOP_INST;
  end

  // Pack the control word consumed by the pipeline controller.
  always_comb begin
    D_out = {inst_eff[30], inst_eff[24:20], inst_eff[19:15],
             inst_eff[14:12], inst_eff[11:7], inst_eff[6:2]};
  end

  // Immediate generation keyed on the opcode bits inst[6:2].
  always_comb begin
    D_imm = 32'h0;
    case (inst_eff[6:2])
      5'b00100, 5'b00000, 5'b11001:
        D_imm = {{20{inst_eff[31]}}, inst_eff[31:20]};
      5'b01000:
        D_imm = {{20{inst_eff[31]}}, inst_eff[31:25], inst_eff[11:7]};
      5'b11000:
        D_imm = {{19{inst_eff[31]}}, inst_eff[31], inst_eff[7],
                 inst_eff[30:25], inst_eff[11:8], 1'b0};
      5'b01101, 5'b00101:
        D_imm = {inst_eff[31:12], 12'h000};
      5'b11011:
        D_imm = {{11{inst_eff[31]}}, inst_eff[31], inst_eff[19:12],
                 inst_eff[20], inst_eff[30:21], 1'b0};
      default: D_imm = 32'h0;
    endcase
  end

  assign im_addr = pc_q;
  assign im_req  = ~stall & next_pc_sel;
  assign D_inst  = inst_eff;
  assign D_pc    = d_pc_q;
  assign D_valid = d_valid_q;

`ifdef IF_ID_PERF_CNT_EN
  // Saturating counters: stalled/waiting edges and redirect edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'h0;
      perf_flush_cnt <= 32'h0;
    end else begin
      if ((act == ACT_HOLD || act == ACT_WAIT) && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (act == ACT_REDIRECT && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
